// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the processor datapath.
// Sequences every instruction through FETCH / EXEC / MEM / WB, with WAIT_IN
// for input handshakes and HALT for the halt/resume loop. Every control output
// is registered and decoded from the next state plus the current opcode.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   opcode, operation   decoded instruction fields from the datapath
//   in_ready, resume    input-device data valid, leave HALT
//   reg_write, mem_write, inst_write, in_req, new_out, pc_write,
//   bios_controll, bios_write_pc           enables / strobes / mode
//   pc_orig, rd_orig, loc_write, op_b, branch_comp, write_d_sel, alu_op
//                                          datapath mux selects
//   halted, illegal, in_timeout            status (illegal, in_timeout sticky)
//   retired             count of cycles with pc_write=1 (instructions done)
module control_fsm #(
   parameter int IN_TIMEOUT = 0,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       opcode,
   input  logic [3:0]       operation,
   input  logic             in_ready,
   input  logic             resume,
   output logic             reg_write,
   output logic             mem_write,
   output logic             inst_write,
   output logic             in_req,
   output logic             new_out,
   output logic             pc_write,
   output logic             bios_controll,
   output logic             bios_write_pc,
   output logic [1:0]       pc_orig,
   output logic [1:0]       rd_orig,
   output logic [1:0]       loc_write,
   output logic [1:0]       op_b,
   output logic [2:0]       branch_comp,
   output logic [3:0]       write_d_sel,
   output logic [3:0]       alu_op,
   output logic             halted,
   output logic             illegal,
   output logic             in_timeout,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_EXEC    = 3'd1,
      S_MEM     = 3'd2,
      S_WB      = 3'd3,
      S_WAIT_IN = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   localparam logic [3:0] OP_ALU_R  = 4'd0;
   localparam logic [3:0] OP_ALU_I  = 4'd1;
   localparam logic [3:0] OP_SHIFT  = 4'd2;
   localparam logic [3:0] OP_LOAD   = 4'd3;
   localparam logic [3:0] OP_STORE  = 4'd4;
   localparam logic [3:0] OP_BRANCH = 4'd5;
   localparam logic [3:0] OP_JUMP   = 4'd6;
   localparam logic [3:0] OP_JR     = 4'd7;
   localparam logic [3:0] OP_IN     = 4'd8;
   localparam logic [3:0] OP_OUT    = 4'd9;
   localparam logic [3:0] OP_MULDIV = 4'd10;
   localparam logic [3:0] OP_MFHL   = 4'd11;
   localparam logic [3:0] OP_SYS    = 4'd12;
   localparam logic [3:0] OP_STI    = 4'd13;
   localparam logic [3:0] OP_HALT   = 4'd14;
   localparam logic [3:0] OP_UNDEF  = 4'd15;

   // Timeout fires at the end of the IN_TIMEOUT-th wait cycle (counter starts at 0).
   localparam logic        TIMEOUT_EN = (IN_TIMEOUT > 0);
   localparam logic [31:0] TO_LAST    = TIMEOUT_EN ? 32'(IN_TIMEOUT - 1) : 32'd0;

   state_t      state_r, next_state_s;
   logic [31:0] wait_cnt_r;
   logic        timeout_hit_s;

   logic       reg_write_s, mem_write_s, inst_write_s, in_req_s, new_out_s;
   logic       pc_write_s, bios_write_pc_s, halted_s;
   logic [1:0] pc_orig_s, rd_orig_s, loc_write_s, op_b_s;
   logic [2:0] branch_comp_s;
   logic [3:0] write_d_sel_s, alu_op_s;

   assign timeout_hit_s = TIMEOUT_EN && (wait_cnt_r == TO_LAST);

   // Next-state logic.
   always_comb begin
      next_state_s = S_FETCH;
      case (state_r)
         S_FETCH: next_state_s = S_EXEC;
         S_EXEC: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state_s = S_MEM;
               OP_IN:             next_state_s = S_WAIT_IN;
               OP_HALT:           next_state_s = S_HALT;
               default:           next_state_s = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (opcode == OP_LOAD) next_state_s = S_WB;
            else                   next_state_s = S_FETCH;
         end
         S_WB: next_state_s = S_FETCH;
         // in_ready wins over a simultaneous timeout; both finish through WB.
         S_WAIT_IN: begin
            if (in_ready || timeout_hit_s) next_state_s = S_WB;
            else                           next_state_s = S_WAIT_IN;
         end
         S_HALT: begin
            if (resume) next_state_s = S_WB;
            else        next_state_s = S_HALT;
         end
         default: next_state_s = S_FETCH;
      endcase
   end

   // Output decode for the cycle that starts at the next clock edge.
   always_comb begin
      reg_write_s     = 1'b0;
      mem_write_s     = 1'b0;
      inst_write_s    = 1'b0;
      in_req_s        = 1'b0;
      new_out_s       = 1'b0;
      pc_write_s      = 1'b0;
      bios_write_pc_s = 1'b0;
      halted_s        = 1'b0;
      pc_orig_s       = 2'd0;
      rd_orig_s       = 2'd0;
      loc_write_s     = 2'd0;
      op_b_s          = 2'd0;
      branch_comp_s   = 3'd0;
      write_d_sel_s   = 4'd0;
      alu_op_s        = 4'd0;
      case (next_state_s)
         S_EXEC: begin
            case (opcode)
               OP_ALU_R: begin
                  alu_op_s = operation; reg_write_s = 1'b1; pc_write_s = 1'b1;
               end
               OP_ALU_I: begin
                  alu_op_s = operation; op_b_s = 2'd1; rd_orig_s = 2'd1;
                  reg_write_s = 1'b1; pc_write_s = 1'b1;
               end
               OP_SHIFT: begin
                  alu_op_s = operation; op_b_s = 2'd2;
                  reg_write_s = 1'b1; pc_write_s = 1'b1;
               end
               OP_LOAD, OP_STORE: op_b_s = 2'd3;
               OP_BRANCH: begin
                  branch_comp_s = operation[2:0]; pc_orig_s = 2'd1; pc_write_s = 1'b1;
               end
               OP_JUMP: begin
                  pc_orig_s = 2'd2; pc_write_s = 1'b1;
                  // operation[0] selects jump-and-link into ra
                  if (operation[0]) begin
                     reg_write_s = 1'b1; loc_write_s = 2'd1;
                  end else begin
                     reg_write_s = 1'b0;
                  end
               end
               OP_JR: begin
                  pc_orig_s = 2'd3; pc_write_s = 1'b1;
               end
               OP_OUT: begin
                  new_out_s = 1'b1; pc_write_s = 1'b1;
               end
               OP_MULDIV: begin
                  alu_op_s = operation; loc_write_s = 2'd2;
                  reg_write_s = 1'b1; pc_write_s = 1'b1;
               end
               OP_MFHL: begin
                  write_d_sel_s = operation[0] ? 4'd4 : 4'd3;
                  reg_write_s = 1'b1; pc_write_s = 1'b1;
               end
               OP_SYS: begin
                  pc_write_s      = 1'b1;
                  bios_write_pc_s = (operation == 4'd1);
               end
               // Instruction memory is writable only while the BIOS runs.
               OP_STI: begin
                  pc_write_s = 1'b1; inst_write_s = bios_controll;
               end
               OP_UNDEF: pc_write_s = 1'b1;
               default: pc_write_s = 1'b0;
            endcase
         end
         S_MEM: begin
            op_b_s = 2'd3;
            if (opcode == OP_STORE) begin
               mem_write_s = 1'b1; pc_write_s = 1'b1;
            end else begin
               mem_write_s = 1'b0;
            end
         end
         S_WB: begin
            case (opcode)
               OP_LOAD: begin
                  op_b_s = 2'd3; write_d_sel_s = 4'd1; rd_orig_s = 2'd1;
                  reg_write_s = 1'b1; pc_write_s = 1'b1;
               end
               OP_IN: begin
                  write_d_sel_s = 4'd2; reg_write_s = 1'b1; pc_write_s = 1'b1;
               end
               default: pc_write_s = 1'b1;   // resume from HALT
            endcase
         end
         S_WAIT_IN: in_req_s = 1'b1;
         S_HALT:    halted_s = 1'b1;
         default:   halted_s = 1'b0;
      endcase
   end

   // State, registered outputs, sticky flags, wait counter and retired count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= S_FETCH;
         wait_cnt_r    <= 32'd0;
         reg_write     <= 1'b0;
         mem_write     <= 1'b0;
         inst_write    <= 1'b0;
         in_req        <= 1'b0;
         new_out       <= 1'b0;
         pc_write      <= 1'b0;
         bios_write_pc <= 1'b0;
         halted        <= 1'b0;
         pc_orig       <= 2'd0;
         rd_orig       <= 2'd0;
         loc_write     <= 2'd0;
         op_b          <= 2'd0;
         branch_comp   <= 3'd0;
         write_d_sel   <= 4'd0;
         alu_op        <= 4'd0;
         bios_controll <= 1'b1;
         illegal       <= 1'b0;
         in_timeout    <= 1'b0;
         retired       <= {CNT_W{1'b0}};
      end else begin
         state_r       <= next_state_s;
         reg_write     <= reg_write_s;
         mem_write     <= mem_write_s;
         inst_write    <= inst_write_s;
         in_req        <= in_req_s;
         new_out       <= new_out_s;
         pc_write      <= pc_write_s;
         bios_write_pc <= bios_write_pc_s;
         halted        <= halted_s;
         pc_orig       <= pc_orig_s;
         rd_orig       <= rd_orig_s;
         loc_write     <= loc_write_s;
         op_b          <= op_b_s;
         branch_comp   <= branch_comp_s;
         write_d_sel   <= write_d_sel_s;
         alu_op        <= alu_op_s;
         if (state_r != S_WAIT_IN) wait_cnt_r <= 32'd0;
         else                      wait_cnt_r <= wait_cnt_r + 32'd1;
         // BIOS mode flips after the SYS instruction's EXEC cycle.
         if (state_r == S_EXEC && opcode == OP_SYS) begin
            if (operation == 4'd0)      bios_controll <= 1'b1;
            else if (operation == 4'd1) bios_controll <= 1'b0;
         end
         if (next_state_s == S_EXEC && opcode == OP_UNDEF) illegal <= 1'b1;
         if (state_r == S_WAIT_IN && !in_ready && timeout_hit_s) in_timeout <= 1'b1;
         // retired moves together with the registered pc_write
         if (pc_write_s) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle control unit that drives every control input of the processor datapath.
- Consumes the datapath's decoded opcode and operation fields and in_ready.
- Sequences each instruction through FETCH/EXEC/MEM/WB.
- Handles input wait and timeout, output pulses, BIOS-mode switching, halt/resume and a retired-instruction count.

Parameters:
IN_TIMEOUT, 0, cycles to wait for in_ready before abandoning IN; 0 = wait forever
CNT_W, 32, width of retired counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
opcode  in  4  instruction class from datapath
operation  in  4  sub-operation from datapath
in_ready  in  1  input device data valid
resume  in  1  leave HALT
reg_write  out  1  register file write enable
mem_write  out  1  data memory write enable
inst_write  out  1  instruction memory write enable
in_req  out  1  input request
new_out  out  1  output strobe
pc_write  out  1  PC update enable
bios_controll  out  1  BIOS mode select
bios_write_pc  out  1  load user PC from read1 on BIOS exit
pc_orig  out  2  0 seq, 1 branch, 2 jump, 3 register
rd_orig  out  2  0 rd, 1 rt, 2 srs, 3 rs
loc_write  out  2  0 gpr, 1 ra, 2 hi/lo
op_b  out  2  0 reg, 1 imm, 2 shift, 3 displacement
branch_comp  out  3  branch condition
write_d_sel  out  4  write-data mux select
alu_op  out  4  ALU operation
halted  out  1  in HALT
illegal  out  1  sticky, undefined opcode seen
in_timeout  out  1  sticky, IN abandoned
retired  out  CNT_W  instructions completed

Behaviour:
- Reset, sampled at posedge clk when rst_n=0:
  - state=FETCH.
  - All enables, strobes and selects 0.
  - bios_controll=1 (boot runs BIOS).
  - Sticky flags 0; retired 0.
  - Reset overrides any state, including WAIT_IN and HALT.
- States: FETCH, EXEC, MEM, WB, WAIT_IN, HALT. All outputs registered, decoded from the next state and the current opcode.
- FETCH: one cycle, no enables, so the instruction settles. Next state is always EXEC.
- Enable rules:
  - Write enables (reg_write, mem_write, inst_write) are asserted for exactly one cycle per instruction.
  - pc_write is asserted exactly once per instruction, in its final cycle, then state returns to FETCH.
- Decode, by opcode:
  - 0 ALU-R: alu_op=operation, op_b=0, rd_orig=0, write_d_sel=0. reg_write+pc_write in EXEC.
  - 1 ALU-I: op_b=1, rd_orig=1, otherwise as ALU-R.
  - 2 SHIFT: op_b=2, otherwise as ALU-R.
  - 3 LOAD: alu_op=0 (add), op_b=3. EXEC → MEM (address held) → WB. In WB: write_d_sel=1, rd_orig=1, reg_write+pc_write.
  - 4 STORE: alu_op=0, op_b=3. EXEC → MEM. In MEM: mem_write+pc_write.
  - 5 BRANCH: branch_comp=operation[2:0], pc_orig=1, pc_write in EXEC.
  - 6 JUMP: pc_orig=2. If operation[0]=1, also reg_write with loc_write=1.
  - 7 JR: pc_orig=3, pc_write.
  - 8 IN: EXEC → WAIT_IN.
    - WAIT_IN: in_req=1 each cycle.
    - When in_ready=1: write_d_sel=2, reg_write+pc_write that cycle, in_req drops the next cycle.
    - If IN_TIMEOUT>0 and the wait counter reaches IN_TIMEOUT without in_ready: write_d_sel=2, reg_write, pc_write, set in_timeout.
    - The counter clears on entry to WAIT_IN.
  - 9 OUT: new_out=1 for exactly one cycle (EXEC), pc_write.
  - 10 MULDIV: alu_op=operation, loc_write=2, reg_write+pc_write.
  - 11 MFHL: write_d_sel=3 if operation[0]=0, else 4. reg_write+pc_write.
  - 12 SYS:
    - operation=0: bios_controll←1 from the next cycle.
    - operation=1: bios_write_pc=1 and pc_write this cycle; bios_controll←0 from the next cycle.
    - Other operation values are treated as NOP.
  - 13 STI: inst_write+pc_write, only when bios_controll=1; otherwise NOP.
  - 14 HALT: go to HALT. No pc_write; halted=1.
    - On resume=1: pc_write one cycle, then FETCH.
    - With resume=0 the state is held indefinitely.
  - 15 undefined: set illegal, pc_write, no other enables (NOP).
- retired: increments by 1 in any cycle where pc_write=1; wraps to 0 at all-ones.
- Simultaneous events:
  - in_ready on the same cycle as timeout expiry counts as a normal completion; in_timeout is not set.
  - in_ready outside WAIT_IN is ignored.

Test Plan:
- Reset mid-LOAD (rst_n=0 in MEM) → next cycle state FETCH, all enables 0, bios_controll=1, retired=0.
- opcode=0, operation=5 → FETCH then EXEC: alu_op=5, reg_write=1 and pc_write=1 for one cycle; retired=1.
- LOAD → reg_write=0 in EXEC and MEM; in WB write_d_sel=1, reg_write=1, pc_write=1; 3 cycles after FETCH.
- IN with IN_TIMEOUT=0, in_ready raised after 7 cycles → in_req high 7 cycles, reg_write on the in_ready cycle, in_timeout=0. With IN_TIMEOUT=4 and no in_ready → completes after 4 wait cycles, in_timeout=1.
- SYS op=1 → bios_write_pc=1 and pc_write=1 together, bios_controll=0 next cycle. Then STI → inst_write stays 0.
- HALT → halted=1, pc_write=0 for 10 cycles; resume=1 → one pc_write, then FETCH. opcode=15 → illegal=1 and stays set after later valid instructions.
